// File: rtl/pkt_ip_hdr_csum.sv
// pkt_ip_hdr_csum: three-stage beat delay line that rewrites the IPv4 header checksum in beat 1.
// Build option: define IP_CSUM_CHECK_EN to flag received checksums that differ from the computed one.
module pkt_ip_hdr_csum (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_data_valid,
    input  logic [133:0] i_data,
    output logic         o_data_valid,
    output logic [133:0] o_data,
    output logic         o_csum_err
);
    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    typedef enum logic [1:0] {IDLE, B1, B2, BODY} state_t;

    state_t        state, state_nx;
    logic          v1, v2;
    logic [133:0]  d1, d2;
    logic [31:0]   part;
    logic [15:0]   csum;
    logic          hdr_ok, ins_pend, ins_nx, err_nx;
    logic          in_head, in_tail, d1_ipv4;
    logic [31:0]   b1_sum;

    function automatic logic [15:0] fold_not(input logic [31:0] s);
        logic [31:0] f;
        f = 32'(s[31:16]) + 32'(s[15:0]);
        f = 32'(f[31:16]) + 32'(f[15:0]);
        return ~f[15:0];
    endfunction

    assign in_head = i_data_valid && (i_data[133:132] == TAG_HEAD);
    assign in_tail = i_data_valid && (i_data[133:132] == TAG_TAIL);
    assign d1_ipv4 = (d1[31:16] == 16'h0800) && (d1[15:12] == 4'd4) && (d1[11:8] == 4'd5);
    // head word (stage 1) plus the beat-1 header words; the checksum field is left out, i.e. zero
    assign b1_sum  = 32'(d1[15:0]) + 32'(i_data[127:112]) + 32'(i_data[111:96]) + 32'(i_data[95:80])
                   + 32'(i_data[79:64]) + 32'(i_data[47:32]) + 32'(i_data[31:16]) + 32'(i_data[15:0]);
    // beat 2 arriving right after an eligible head/beat1 pair schedules the rewrite of beat 1
    assign ins_nx  = (state == B2) && i_data_valid && !in_head && hdr_ok;

`ifdef IP_CSUM_CHECK_EN
    assign err_nx = ins_pend && (d2[63:48] != csum);
`else
    assign err_nx = 1'b0;
`endif

    // packet tracker next state: gaps and tails drop to idle, a head always restarts
    always_comb begin
        state_nx = !i_data_valid ? IDLE :
                   in_head       ? B1   :
                   in_tail       ? IDLE :
                   state == B1   ? B2   :
                   state == B2   ? BODY : state;
    end

    // tracker state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    // header sums: partial when beat 1 arrives, final checksum when beat 2 arrives
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            part     <= '0;
            csum     <= '0;
            hdr_ok   <= 1'b0;
            ins_pend <= 1'b0;
        end else begin
            if (state == B1) part <= b1_sum;
            if (state == B2) csum <= fold_not(part + 32'(i_data[127:112]));
            hdr_ok   <= (state == B1) && i_data_valid && !in_head && !in_tail && d1_ipv4;
            ins_pend <= ins_nx;
        end
    end

    // delay line; the last stage patches the checksum field of an eligible beat 1
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1           <= 1'b0;
            v2           <= 1'b0;
            d1           <= '0;
            d2           <= '0;
            o_data_valid <= 1'b0;
            o_data       <= '0;
            o_csum_err   <= 1'b0;
        end else begin
            v1           <= i_data_valid;
            d1           <= i_data;
            v2           <= v1;
            d2           <= d1;
            o_data_valid <= v2;
            o_data       <= ins_pend ? {d2[133:64], csum, d2[47:0]} : d2;
            o_csum_err   <= err_nx;
        end
    end
endmodule

// File: tb/tb_pkt_ip_hdr_csum.sv
// tb_pkt_ip_hdr_csum: table-driven check of checksum insertion, pass-through cases and reset recovery.
module tb_pkt_ip_hdr_csum;
`ifdef IP_CSUM_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    typedef struct {
        logic         v;
        logic [133:0] d;
        logic [133:0] e;
        logic         err;
    } vec_t;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_data_valid = 1'b0;
    logic [133:0] i_data = '0;
    logic         o_data_valid;
    logic [133:0] o_data;
    logic         o_csum_err;
    int           checks = 0;
    int           errs = 0;
    vec_t         tbl[$];

    pkt_ip_hdr_csum dut (
        .i_clk(clk), .i_rst(i_rst), .i_data_valid(i_data_valid), .i_data(i_data),
        .o_data_valid(o_data_valid), .o_data(o_data), .o_csum_err(o_csum_err)
    );

    always #5 clk = ~clk;

    function automatic logic [133:0] bt(input logic [1:0] tag, input logic [3:0] code, input logic [127:0] p);
        return {tag, code, p};
    endfunction

    function automatic logic [133:0] hd(input logic [15:0] et, input logic [15:0] vi);
        return bt(2'b01, 4'h0, {96'h0011_2233_4455_6677_8899_aabb, et, vi});
    endfunction

    function automatic logic [133:0] b1a(input logic [1:0] tag, input logic [15:0] c);
        return bt(tag, 4'h0, {16'h0073, 16'h0000, 16'h4000, 16'h4011, c, 16'hc0a8, 16'h0001, 16'hc0a8});
    endfunction

    function automatic logic [133:0] b1b(input logic [15:0] c);
        return bt(2'b11, 4'h0, {16'h0030, 16'h4422, 16'h4000, 16'h8006, c, 16'h8c7c, 16'h19ac, 16'hae24});
    endfunction

    localparam logic [133:0] B2A = {2'b11, 4'h0, 16'h00c7, 112'h1111_2222_3333_4444_5555_6666_7777};
    localparam logic [133:0] B2B = {2'b11, 4'h0, 16'h1e2b, 112'h8888_9999_aaaa_bbbb_cccc_dddd_eeee};
    localparam logic [133:0] TL  = {2'b10, 4'h5, 128'hcafe_f00d_0bad_beef_1357_9bdf_2468_ace0};
    localparam logic [133:0] BD  = {2'b11, 4'h0, 128'h0f0f_0f0f_a5a5_a5a5_5a5a_5a5a_f0f0_f0f0};
    localparam logic [133:0] IDL = {2'b11, 4'hf, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210};

    task automatic add(input logic v, input logic [133:0] d, input logic [133:0] e, input logic err);
        vec_t r;
        r.v = v; r.d = d; r.e = e; r.err = err;
        tbl.push_back(r);
    endtask

    task automatic same(input logic [133:0] d);
        add(1'b1, d, d, 1'b0);
    endtask

    task automatic idle();
        add(1'b0, IDL, IDL, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_row(input int r);
        chk($sformatf("row%0d valid", r), 134'(o_data_valid), 134'(tbl[r].v));
        chk($sformatf("row%0d data", r), o_data, tbl[r].e);
        chk($sformatf("row%0d csum_err", r), 134'(o_csum_err), 134'(tbl[r].err));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " valid"}, 134'(o_data_valid), 134'd0);
        chk({nm, " data"}, o_data, 134'd0);
        chk({nm, " csum_err"}, 134'(o_csum_err), 134'd0);
    endtask

    // drives rows lo..hi-1 one per cycle and checks each one three cycles later
    task automatic run(input int lo, input int hi);
        for (int n = lo; n < hi + 3; n++) begin
            @(negedge clk);
            if (n >= lo + 3) chk_row(n - 3);
            i_data_valid = (n < hi) ? tbl[n].v : 1'b0;
            i_data       = (n < hi) ? tbl[n].d : '0;
        end
    endtask

    initial begin
        int seg1;
        same(hd(16'h0800, 16'h4500)); add(1'b1, b1a(2'b11, 16'h0000), b1a(2'b11, 16'hb861), CHK);
        same(B2A); same(TL); idle();
        same(hd(16'h0800, 16'h4500)); add(1'b1, b1a(2'b11, 16'h1234), b1a(2'b11, 16'hb861), CHK);
        same(B2A); same(TL); idle();
        same(hd(16'h0800, 16'h4500)); same(b1a(2'b11, 16'hb861)); same(B2A); same(TL); idle();
        same(hd(16'h86dd, 16'h4500)); same(b1a(2'b11, 16'h0000)); same(B2A); same(TL);
        same(hd(16'h0800, 16'h4600)); same(b1a(2'b11, 16'h0000)); same(B2A); same(TL); idle();
        same(hd(16'h0800, 16'h4500)); same(b1a(2'b11, 16'h0000)); idle(); same(B2A); same(TL);
        same(hd(16'h0800, 16'h4500)); add(1'b1, b1a(2'b11, 16'h0000), b1a(2'b11, 16'hb861), CHK);
        same(B2A); same(TL);
        same(hd(16'h0800, 16'h4500)); add(1'b1, b1b(16'h0000), b1b(16'h442e), CHK);
        same(B2B); same(TL); idle();
        same(BD); same(TL); idle();
        same(hd(16'h0800, 16'h4500)); same(b1a(2'b10, 16'h0000)); idle();
        same(hd(16'h0800, 16'h4500)); same(hd(16'h0800, 16'h4500));
        add(1'b1, b1b(16'h0000), b1b(16'h442e), CHK); same(B2B); same(TL); idle();
        seg1 = tbl.size();
        same(BD); same(hd(16'h0800, 16'h4500)); add(1'b1, b1b(16'h0000), b1b(16'h442e), CHK);
        same(B2B); same(TL);

        repeat (2) @(negedge clk);
        chk_zero("reset");
        i_rst = 1'b0;
        run(0, seg1);

        @(negedge clk); i_data_valid = 1'b1; i_data = hd(16'h0800, 16'h4500);
        @(negedge clk); i_data = b1a(2'b11, 16'h0000);
        @(negedge clk); i_rst = 1'b1; i_data_valid = 1'b0; i_data = '0;
        #1 chk_zero("mid-reset 0");
        @(negedge clk); chk_zero("mid-reset 1");
        i_rst = 1'b0;
        run(seg1, tbl.size());

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
